// File: rtl/move_pkg.sv
// Shared encodings for the move validator: cell codes, illegal-move codes, FSM states.
// Latency: n/a (types and a helper function only).
// Backpressure: n/a.
package move_pkg;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_PL1   = 2'b01,
    CELL_PL2   = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    ILL_NONE  = 2'b00,
    ILL_OCC   = 2'b01,
    ILL_TURN  = 2'b10,
    ILL_RANGE = 2'b11
  } ill_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCEPT = 2'b01,
    S_CHECK  = 2'b10,
    S_DONE   = 2'b11
  } state_t;

  // Board code written for a player bit (0 = PL1, 1 = PL2)
  function automatic cell_t player_code(input logic player);
    return player ? CELL_PL2 : CELL_PL1;
  endfunction

endpackage

// File: rtl/move_validator_strike_counter.sv
// Saturating per-player illegal-move counter; at_max flags forfeit, hit flags the move reaching it.
// Latency: count updates at the edge after inc; hit is combinational from inc and the count.
// Backpressure: none; clr wins over inc.
module strike_counter #(
  parameter int MAX = 3,
  localparam int CW = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic at_max,
  output logic hit
);

  logic [CW-1:0] count;

  // Count strikes, holding at MAX once reached
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != CW'(MAX))) begin
      count <= count + 1'b1;
    end
  end

  assign at_max = (count == CW'(MAX));
  // This increment is the one that lands on (or is already at) MAX
  assign hit    = inc && (count >= CW'(MAX - 1));

endmodule

// File: rtl/move_validator.sv
// Owns the board, accepts one move per handshake, classifies it and commits legal moves.
// Latency: pulse and board/turn/count update 1 cycle after the handshake edge; one move per 2 cycles.
// Backpressure: move_ready low outside ACCEPT and while game_over/board_full/start; optional strikes via MOVE_VALIDATOR_STRIKE_EN.
module move_validator
  import move_pkg::*;
#(
  parameter int N_CELLS     = 9,
  parameter int MAX_STRIKES = 3,
  localparam int IDX_W = $clog2(N_CELLS),
  localparam int CNT_W = $clog2(N_CELLS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 game_over,
  input  logic                 move_valid,
  output logic                 move_ready,
  input  logic                 move_player,
  input  logic [IDX_W-1:0]     move_cell,
  output logic [2*N_CELLS-1:0] board,
  output logic                 turn,
  output logic                 legal_pulse,
  output logic                 illegal_pulse,
  output logic [1:0]           illegal_code,
  output logic                 board_full,
  output logic [CNT_W-1:0]     move_count
`ifdef MOVE_VALIDATOR_STRIKE_EN
  ,
  output logic [1:0]           forfeit
`endif
);

  state_t          state;
  state_t          next_state;
  logic            lat_player;
  logic [IDX_W-1:0] lat_cell;
  logic [31:0]     cell_ext;
  logic            out_range;
  logic            wrong_turn;
  logic            occupied;
  logic            legal;
  ill_t            chk_code;
  logic            xfer;
  logic            check_illegal;
  logic            forfeit_now;

  assign xfer          = move_valid && move_ready;
  assign board_full    = (move_count == CNT_W'(N_CELLS));
  assign cell_ext      = 32'(lat_cell);
  assign check_illegal = (state == S_CHECK) && !legal && !start;

`ifdef MOVE_VALIDATOR_STRIKE_EN
  logic [1:0] strike_hit;

  strike_counter #(.MAX(MAX_STRIKES)) u_strike_pl1 (
    .clk    (clk),
    .reset  (reset),
    .clr    (start),
    .inc    (check_illegal && !lat_player),
    .at_max (forfeit[0]),
    .hit    (strike_hit[0])
  );

  strike_counter #(.MAX(MAX_STRIKES)) u_strike_pl2 (
    .clk    (clk),
    .reset  (reset),
    .clr    (start),
    .inc    (check_illegal && lat_player),
    .at_max (forfeit[1]),
    .hit    (strike_hit[1])
  );

  assign forfeit_now = lat_player ? strike_hit[1] : strike_hit[0];
`else
  assign forfeit_now = 1'b0;
  // Illegal moves never end the game here; MAX_STRIKES only sanity-checked
  if (MAX_STRIKES < 1) begin : g_bad_max_strikes
  end
`endif

  // Classify the latched move: range beats turn beats occupancy
  always_comb begin
    out_range  = (cell_ext >= 32'(N_CELLS));
    wrong_turn = (lat_player != turn);
    occupied   = 1'b0;
    for (int i = 0; i < N_CELLS; i++) begin
      if ((cell_ext == 32'(i)) && (board[2*i +: 2] != CELL_EMPTY)) begin
        occupied = 1'b1;
      end
    end
    legal = !out_range && !wrong_turn && !occupied;
    if (out_range) begin
      chk_code = ILL_RANGE;
    end else if (wrong_turn) begin
      chk_code = ILL_TURN;
    end else if (occupied) begin
      chk_code = ILL_OCC;
    end else begin
      chk_code = ILL_NONE;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and ready; start overrides every state
  always_comb begin
    next_state = state;
    move_ready = 1'b0;
    case (state)
      S_IDLE: begin
      end
      S_ACCEPT: begin
        // start also drops ready so a move is never taken in the cycle it would be discarded
        move_ready = !game_over && !board_full && !start;
        if (game_over || board_full) begin
          next_state = S_DONE;
        end else if (move_valid) begin
          next_state = S_CHECK;
        end
      end
      S_CHECK: begin
        if (legal && (move_count == CNT_W'(N_CELLS - 1))) begin
          next_state = S_DONE;
        end else if (!legal && forfeit_now) begin
          next_state = S_DONE;
        end else begin
          next_state = S_ACCEPT;
        end
      end
      S_DONE: begin
      end
      default: next_state = S_IDLE;
    endcase
    if (start) begin
      next_state = S_ACCEPT;
    end
  end

  // Latch requests, commit legal moves, strobe results
  always_ff @(posedge clk) begin
    if (reset) begin
      board         <= '0;
      turn          <= 1'b0;
      move_count    <= '0;
      legal_pulse   <= 1'b0;
      illegal_pulse <= 1'b0;
      illegal_code  <= ILL_NONE;
      lat_player    <= 1'b0;
      lat_cell      <= '0;
    end else begin
      legal_pulse   <= 1'b0;
      illegal_pulse <= 1'b0;
      if (start) begin
        board        <= '0;
        turn         <= 1'b0;
        move_count   <= '0;
        illegal_code <= ILL_NONE;
      end else begin
        if (xfer) begin
          lat_player <= move_player;
          lat_cell   <= move_cell;
        end
        if (state == S_CHECK) begin
          if (legal) begin
            for (int i = 0; i < N_CELLS; i++) begin
              if (cell_ext == 32'(i)) begin
                board[2*i +: 2] <= player_code(lat_player);
              end
            end
            move_count   <= move_count + 1'b1;
            turn         <= !turn;
            legal_pulse  <= 1'b1;
            illegal_code <= ILL_NONE;
          end else begin
            illegal_pulse <= 1'b1;
            illegal_code  <= chk_code;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_move_validator.sv
// Directed bench for move_validator: handshake timing, classification priority, full board, game_over, start/reset mid-CHECK.
// Latency: each move takes the handshake edge plus one edge to its pulse.
// Backpressure: waits on move_ready are bounded; strike tests run when MOVE_VALIDATOR_STRIKE_EN is defined.
module tb_move_validator;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        game_over;
  logic        move_valid;
  logic        move_ready;
  logic        move_player;
  logic [3:0]  move_cell;
  logic [17:0] board;
  logic        turn;
  logic        legal_pulse;
  logic        illegal_pulse;
  logic [1:0]  illegal_code;
  logic        board_full;
  logic [3:0]  move_count;
`ifdef MOVE_VALIDATOR_STRIKE_EN
  logic [1:0]  forfeit;
`endif

  int errors = 0;
  int checks = 0;

  move_validator #(.N_CELLS(9), .MAX_STRIKES(3)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .game_over     (game_over),
    .move_valid    (move_valid),
    .move_ready    (move_ready),
    .move_player   (move_player),
    .move_cell     (move_cell),
    .board         (board),
    .turn          (turn),
    .legal_pulse   (legal_pulse),
    .illegal_pulse (illegal_pulse),
    .illegal_code  (illegal_code),
    .board_full    (board_full),
    .move_count    (move_count)
`ifdef MOVE_VALIDATOR_STRIKE_EN
    ,
    .forfeit       (forfeit)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_game();
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    chk("ready_after_start", move_ready, 1);
  endtask

  // Offer a move, complete the handshake, return just after the result edge
  task automatic do_move(input logic p, input logic [3:0] c);
    int n;
    move_player = p;
    move_cell   = c;
    move_valid  = 1'b1;
    #1;
    n = 0;
    while (!move_ready && n < 10) begin
      tick();
      n++;
    end
    chk("ready_before_move", move_ready, 1);
    tick();
    move_valid = 1'b0;
    #1;
    chk("ready_in_check", move_ready, 0);
    chk("no_pulse_in_check", {legal_pulse, illegal_pulse}, 0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    game_over   = 1'b0;
    move_valid  = 1'b0;
    move_player = 1'b0;
    move_cell   = 4'd0;
    tick();
    tick();
    // Reset state
    chk("rst_ready", move_ready, 0);
    chk("rst_board", board, 0);
    chk("rst_turn", turn, 0);
    chk("rst_count", move_count, 0);
    chk("rst_pulses", {legal_pulse, illegal_pulse}, 0);
    chk("rst_code", illegal_code, 0);
    chk("rst_full", board_full, 0);
`ifdef MOVE_VALIDATOR_STRIKE_EN
    chk("rst_forfeit", forfeit, 0);
`endif
    reset = 1'b0;
    tick();
    chk("idle_ready", move_ready, 0);

    // Two legal moves: PL1 cell 4 (bits 9:8 = 01), PL2 cell 0 (bits 1:0 = 10)
    start_game();
    do_move(1'b0, 4'd4);
    chk("m1_legal", legal_pulse, 1);
    chk("m1_illegal", illegal_pulse, 0);
    chk("m1_board", board, 18'h00100);
    chk("m1_count", move_count, 1);
    chk("m1_turn", turn, 1);
    chk("m1_ready_same_cycle", move_ready, 1);
    tick();
    chk("m1_pulse_one_cycle", legal_pulse, 0);
    do_move(1'b1, 4'd0);
    chk("m2_legal", legal_pulse, 1);
    chk("m2_board", board, 18'h00102);
    chk("m2_count", move_count, 2);
    chk("m2_turn", turn, 0);

    // Occupied: PL1 cell 4 then PL2 cell 4
    start_game();
    chk("start_clears_board", board, 0);
    do_move(1'b0, 4'd4);
    do_move(1'b1, 4'd4);
    chk("occ_illegal", illegal_pulse, 1);
    chk("occ_legal", legal_pulse, 0);
    chk("occ_code", illegal_code, 2'b01);
    chk("occ_board", board, 18'h00100);
    chk("occ_turn", turn, 1);
    chk("occ_count", move_count, 1);

    // Wrong turn, then range outranks turn, code held, then a legal move clears it
    start_game();
    do_move(1'b1, 4'd3);
    chk("turn_illegal", illegal_pulse, 1);
    chk("turn_code", illegal_code, 2'b10);
    chk("turn_turn", turn, 0);
    do_move(1'b1, 4'd9);
    chk("range_code", illegal_code, 2'b11);
    chk("range_board", board, 0);
    tick();
    chk("range_code_held", illegal_code, 2'b11);
    chk("range_pulse_gone", illegal_pulse, 0);
    do_move(1'b0, 4'd2);
    chk("after_ill_legal", legal_pulse, 1);
    chk("after_ill_code", illegal_code, 2'b00);
    chk("after_ill_board", board, 18'h00010);

    // Nine alternating legal moves fill the board: cells 01,10,01,... -> 0x19999
    start_game();
    for (int i = 0; i < 9; i++) begin
      do_move(1'(i % 2), 4'(i));
      chk("fill_legal", legal_pulse, 1);
    end
    chk("full_flag", board_full, 1);
    chk("full_ready", move_ready, 0);
    chk("full_count", move_count, 9);
    chk("full_board", board, 18'h19999);
    move_valid  = 1'b1;
    move_player = 1'b1;
    move_cell   = 4'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("full_no_pulse", {legal_pulse, illegal_pulse}, 0);
      chk("full_ready_low", move_ready, 0);
    end
    move_valid = 1'b0;
    start_game();
    chk("rearm_board", board, 0);
    chk("rearm_count", move_count, 0);
    chk("rearm_full", board_full, 0);

    // game_over in ACCEPT drops ready at once and parks in DONE
    game_over   = 1'b1;
    move_valid  = 1'b1;
    move_player = 1'b0;
    move_cell   = 4'd1;
    #1;
    chk("go_ready_comb", move_ready, 0);
    tick();
    game_over = 1'b0;
    #1;
    chk("go_done_ready", move_ready, 0);
    tick();
    chk("go_no_pulse", {legal_pulse, illegal_pulse}, 0);
    chk("go_count", move_count, 0);
    move_valid = 1'b0;
    start_game();

    // start during CHECK discards the move with no pulse
    move_valid  = 1'b1;
    move_player = 1'b0;
    move_cell   = 4'd4;
    tick();
    move_valid = 1'b0;
    start      = 1'b1;
    tick();
    start = 1'b0;
    #1;
    chk("startchk_pulses", {legal_pulse, illegal_pulse}, 0);
    chk("startchk_board", board, 0);
    chk("startchk_count", move_count, 0);
    chk("startchk_ready", move_ready, 1);

`ifdef MOVE_VALIDATOR_STRIKE_EN
    // PL2 strikes out on three occupied-cell attempts
    start_game();
    do_move(1'b0, 4'd4);
    do_move(1'b1, 4'd4);
    chk("strike1_illegal", illegal_pulse, 1);
    chk("strike1_forfeit", forfeit, 0);
    do_move(1'b1, 4'd4);
    chk("strike2_forfeit", forfeit, 0);
    do_move(1'b1, 4'd4);
    chk("strike3_illegal", illegal_pulse, 1);
    chk("strike3_code", illegal_code, 2'b01);
    chk("strike3_forfeit", forfeit, 2'b10);
    chk("strike3_ready", move_ready, 0);
    start_game();
    chk("strike_clear", forfeit, 0);
`endif

    // Reset while a move sits in CHECK: everything back to reset values, no pulse
    start_game();
    do_move(1'b0, 4'd4);
    do_move(1'b0, 4'd3);
    chk("pre_rst_code", illegal_code, 2'b10);
    move_valid  = 1'b1;
    move_player = 1'b1;
    move_cell   = 4'd0;
    tick();
    move_valid = 1'b0;
    reset      = 1'b1;
    tick();
    chk("rstchk_pulses", {legal_pulse, illegal_pulse}, 0);
    chk("rstchk_board", board, 0);
    chk("rstchk_count", move_count, 0);
    chk("rstchk_turn", turn, 0);
    chk("rstchk_code", illegal_code, 0);
    chk("rstchk_ready", move_ready, 0);
    reset = 1'b0;
    tick();
    chk("rstchk_idle", move_ready, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
